// File: rtl/qpu_evq_pkg.sv
// Shared types and helpers for the QIU event queue: slot layout, derived widths,
// accumulator state encoding and the wrap-safe due comparison.
package qpu_evq_pkg;

  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_OPEN  = 1'b1
  } acc_state_e;

  function automatic int event_num(input int qubit_num);
    return qubit_num + 2;
  endfunction

  function automatic int edata_w(input int qubit_num, input int opc_w);
    return (qubit_num + 1) * opc_w + qubit_num;
  endfunction

  function automatic int xy_off(input int k, input int opc_w);
    return k * opc_w;
  endfunction

  function automatic int z_off(input int qubit_num, input int opc_w);
    return qubit_num * opc_w;
  endfunction

  function automatic int meas_off(input int qubit_num, input int opc_w);
    return (qubit_num + 1) * opc_w;
  endfunction

  // Due when (tmr - head_t) mod 2^time_w has a clear MSB; the low bits of a wide
  // subtraction of zero-extended operands equal the modular difference.
  function automatic logic is_due(input logic [63:0] tmr, input logic [63:0] head_t,
                                  input int time_w);
    logic [63:0] diff_s;
    diff_s = tmr - head_t;
    return ~diff_s[time_w-1];
  endfunction

endpackage

// File: rtl/qpu_evq_fifo.sv
// Synchronous bundle FIFO with full/empty/level; a push into a full FIFO is dropped
// even when a pop happens in the same cycle.
module qpu_evq_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full     = (level_r == LVL_W'(DEPTH));
  assign empty    = (level_r == '0);
  assign level    = level_r;
  assign pop_data = mem_r[rd_ptr_r];
  assign wr_en_s  = push & ~full;
  assign rd_en_s  = pop & ~empty;

  // Storage, pointers and occupancy; reset clears the array so outputs read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/qpu_exu_qiu_evq.sv
// QIU event queue: formats instructions into XY/Z/measure slots, merges same-time-point
// instructions, queues bundles and issues each when the timer reaches its timestamp.
// Optional build macro QPU_EVQ_LATE_CNT_EN adds late-issue pulse and saturating counter.
module qpu_exu_qiu_evq
  import qpu_evq_pkg::*;
#(
  parameter  int QUBIT_NUM = 8,
  parameter  int OPC_W     = 8,
  parameter  int TIME_W    = 16,
  parameter  int DEPTH     = 8,
  localparam int EVENT_NUM = event_num(QUBIT_NUM),
  localparam int EDATA_W   = edata_w(QUBIT_NUM, OPC_W),
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [QUBIT_NUM-1:0] i_rs1,
  input  logic [QUBIT_NUM-1:0] i_rs2,
  input  logic [OPC_W-1:0]     i_opc1,
  input  logic [OPC_W-1:0]     i_opc2,
  input  logic                 i_qop1_gate,
  input  logic                 i_qop2_gate,
  input  logic                 i_measure,
  input  logic                 i_ntp,
  input  logic [TIME_W-1:0]    i_tdata,
  input  logic                 i_flush,
  input  logic                 i_tmr_en,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [EDATA_W-1:0]   o_edata,
  output logic [EVENT_NUM-1:0] o_oprand,
  output logic [TIME_W-1:0]    o_tdata,
  output logic [LVL_W-1:0]     o_level,
  output logic [TIME_W-1:0]    o_tmr
`ifdef QPU_EVQ_LATE_CNT_EN
  ,
  output logic                 o_late,
  output logic [15:0]          o_late_cnt
`endif
);

  localparam int Z_OFF    = z_off(QUBIT_NUM, OPC_W);
  localparam int MEAS_OFF = meas_off(QUBIT_NUM, OPC_W);
  localparam int ENTRY_W  = TIME_W + EVENT_NUM + EDATA_W;

  acc_state_e           acc_state_r;
  logic [EDATA_W-1:0]   acc_edata_r;
  logic [EVENT_NUM-1:0] acc_oprand_r;
  logic [TIME_W-1:0]    acc_tdata_r;
  logic [TIME_W-1:0]    tmr_r;

  logic [EDATA_W-1:0]   fmt_edata_s;
  logic [EVENT_NUM-1:0] fmt_oprand_s;
  logic [EDATA_W-1:0]   merge_edata_s;
  logic [EVENT_NUM-1:0] merge_oprand_s;

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [ENTRY_W-1:0]   head_s;
  logic [TIME_W-1:0]    head_t_s;
  logic                 acc_open_s;
  logic                 accept_s;
  logic                 ntp_push_s;
  logic                 flush_push_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 due_s;

  assign acc_open_s   = (acc_state_r == ACC_OPEN);
  assign i_ready      = ~rst & ~i_flush & ~(acc_open_s & i_ntp & fifo_full_s);
  assign accept_s     = i_valid & i_ready;
  assign ntp_push_s   = accept_s & acc_open_s & i_ntp;
  assign flush_push_s = acc_open_s & i_flush & ~fifo_full_s;
  assign push_s       = ntp_push_s | flush_push_s;

  assign head_t_s = head_s[EDATA_W+EVENT_NUM +: TIME_W];
  assign due_s    = is_due(64'(tmr_r), 64'(head_t_s), TIME_W);
  assign o_valid  = ~fifo_empty_s & due_s;
  assign pop_s    = o_valid & o_ready;
  assign o_edata  = head_s[0 +: EDATA_W];
  assign o_oprand = head_s[EDATA_W +: EVENT_NUM];
  assign o_tdata  = head_t_s;
  assign o_tmr    = tmr_r;

  // Format one instruction into slots; opc2 wins over opc1 on a shared XY slot.
  always_comb begin
    fmt_edata_s  = '0;
    fmt_oprand_s = '0;
    if (i_measure) begin
      fmt_edata_s[MEAS_OFF +: QUBIT_NUM] = i_rs1;
      fmt_oprand_s[QUBIT_NUM+1]          = 1'b1;
    end else begin
      for (int k = 0; k < QUBIT_NUM; k++) begin
        if (i_rs2[k] & ~i_qop2_gate) begin
          fmt_edata_s[xy_off(k, OPC_W) +: OPC_W] = i_opc2;
          fmt_oprand_s[k]                        = 1'b1;
        end else if (i_rs1[k] | i_qop1_gate) begin
          fmt_edata_s[xy_off(k, OPC_W) +: OPC_W] = i_opc1;
          fmt_oprand_s[k]                        = 1'b1;
        end else begin
          fmt_oprand_s[k] = 1'b0;
        end
      end
    end
    if (i_qop2_gate) begin
      fmt_edata_s[Z_OFF +: OPC_W] = i_opc2;
      fmt_oprand_s[QUBIT_NUM]     = 1'b1;
    end else begin
      fmt_oprand_s[QUBIT_NUM] = 1'b0;
    end
  end

  // Merge: written slots overwrite, unwritten slots keep the accumulator contents.
  always_comb begin
    merge_edata_s  = acc_edata_r;
    merge_oprand_s = acc_oprand_r | fmt_oprand_s;
    for (int k = 0; k < QUBIT_NUM; k++) begin
      if (fmt_oprand_s[k]) begin
        merge_edata_s[xy_off(k, OPC_W) +: OPC_W] = fmt_edata_s[xy_off(k, OPC_W) +: OPC_W];
      end else begin
        merge_edata_s[xy_off(k, OPC_W) +: OPC_W] = acc_edata_r[xy_off(k, OPC_W) +: OPC_W];
      end
    end
    if (fmt_oprand_s[QUBIT_NUM]) begin
      merge_edata_s[Z_OFF +: OPC_W] = fmt_edata_s[Z_OFF +: OPC_W];
    end else begin
      merge_edata_s[Z_OFF +: OPC_W] = acc_edata_r[Z_OFF +: OPC_W];
    end
    if (fmt_oprand_s[QUBIT_NUM+1]) begin
      merge_edata_s[MEAS_OFF +: QUBIT_NUM] = fmt_edata_s[MEAS_OFF +: QUBIT_NUM];
    end else begin
      merge_edata_s[MEAS_OFF +: QUBIT_NUM] = acc_edata_r[MEAS_OFF +: QUBIT_NUM];
    end
  end

  // Accumulator FSM: load on first accept or new time point, merge otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state_r  <= ACC_EMPTY;
      acc_edata_r  <= '0;
      acc_oprand_r <= '0;
      acc_tdata_r  <= '0;
    end else if (flush_push_s) begin
      acc_state_r  <= ACC_EMPTY;
      acc_edata_r  <= '0;
      acc_oprand_r <= '0;
      acc_tdata_r  <= '0;
    end else if (accept_s) begin
      acc_state_r <= ACC_OPEN;
      if (!acc_open_s || i_ntp) begin
        acc_edata_r  <= fmt_edata_s;
        acc_oprand_r <= fmt_oprand_s;
        acc_tdata_r  <= i_tdata;
      end else begin
        acc_edata_r  <= merge_edata_s;
        acc_oprand_r <= merge_oprand_s;
      end
    end
  end

  // Free-running timestamp timer, wraps modulo 2^TIME_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_r <= '0;
    end else if (i_tmr_en) begin
      tmr_r <= tmr_r + TIME_W'(1);
    end
  end

  qpu_evq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({acc_tdata_r, acc_oprand_r, acc_edata_r}),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (o_level)
  );

`ifdef QPU_EVQ_LATE_CNT_EN
  // Late-issue pulse and saturating count for bundles popped after their time point.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_late     <= 1'b0;
      o_late_cnt <= 16'd0;
    end else begin
      o_late <= pop_s & (tmr_r != head_t_s);
      if (pop_s && (tmr_r != head_t_s) && (o_late_cnt != 16'hFFFF)) begin
        o_late_cnt <= o_late_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qpu_exu_qiu_evq.sv
// Directed self-checking bench for qpu_exu_qiu_evq with QUBIT_NUM=4, OPC_W=4, TIME_W=8, DEPTH=4.
module tb_qpu_exu_qiu_evq;

  localparam int QN = 4;
  localparam int OW = 4;
  localparam int TW = 8;
  localparam int DP = 4;
  localparam int EN = QN + 2;
  localparam int EW = (QN + 1) * OW + QN;
  localparam int LW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [QN-1:0] i_rs1;
  logic [QN-1:0] i_rs2;
  logic [OW-1:0] i_opc1;
  logic [OW-1:0] i_opc2;
  logic          i_qop1_gate;
  logic          i_qop2_gate;
  logic          i_measure;
  logic          i_ntp;
  logic [TW-1:0] i_tdata;
  logic          i_flush;
  logic          i_tmr_en;
  logic          o_valid;
  logic          o_ready;
  logic [EW-1:0] o_edata;
  logic [EN-1:0] o_oprand;
  logic [TW-1:0] o_tdata;
  logic [LW-1:0] o_level;
  logic [TW-1:0] o_tmr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qpu_exu_qiu_evq #(
    .QUBIT_NUM (QN),
    .OPC_W     (OW),
    .TIME_W    (TW),
    .DEPTH     (DP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_opc1      (i_opc1),
    .i_opc2      (i_opc2),
    .i_qop1_gate (i_qop1_gate),
    .i_qop2_gate (i_qop2_gate),
    .i_measure   (i_measure),
    .i_ntp       (i_ntp),
    .i_tdata     (i_tdata),
    .i_flush     (i_flush),
    .i_tmr_en    (i_tmr_en),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_edata     (o_edata),
    .o_oprand    (o_oprand),
    .o_tdata     (o_tdata),
    .o_level     (o_level),
    .o_tmr       (o_tmr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] opc1,
                       input logic [3:0] opc2, input logic g1, input logic g2,
                       input logic meas, input logic ntp, input logic [7:0] td);
    i_rs1 = rs1; i_rs2 = rs2; i_opc1 = opc1; i_opc2 = opc2;
    i_qop1_gate = g1; i_qop2_gate = g2; i_measure = meas; i_ntp = ntp; i_tdata = td;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_ntp   = 1'b0;
  endtask

  task automatic flush();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  task automatic run_to_due(input string tag);
    bit found;
    found    = 1'b0;
    i_tmr_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (o_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    i_tmr_en = 1'b0;
    chk(tag, 64'(found), 64'd1);
  endtask

  task automatic pop();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_rs1 = '0; i_rs2 = '0; i_opc1 = '0; i_opc2 = '0;
    i_qop1_gate = 1'b0; i_qop2_gate = 1'b0; i_measure = 1'b0; i_ntp = 1'b0;
    i_tdata = '0; i_flush = 1'b0; i_tmr_en = 1'b0; o_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(i_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_tmr", 64'(o_tmr), 64'd0);
    chk("rst_edata", 64'(o_edata), 64'd0);

    // Single bundle issued exactly at its timestamp
    instr(4'b0101, 4'b0000, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
    flush();
    chk("t1_level", 64'(o_level), 64'd1);
    chk("t1_not_due", 64'(o_valid), 64'd0);
    run_to_due("t1_due");
    chk("t1_tmr", 64'(o_tmr), 64'd10);
    chk("t1_edata", 64'(o_edata), 64'h000303);
    chk("t1_oprand", 64'(o_oprand), 64'b000101);
    chk("t1_tdata", 64'(o_tdata), 64'd10);
    pop();
    chk("t1_pop_level", 64'(o_level), 64'd0);
    chk("t1_pop_valid", 64'(o_valid), 64'd0);

    // Merge keeps the first timestamp
    instr(4'b0001, 4'b0000, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd20);
    instr(4'b0000, 4'b0010, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd99);
    flush();
    chk("t2_level", 64'(o_level), 64'd1);
    chk("t2_tdata", 64'(o_tdata), 64'd20);
    chk("t2_edata", 64'(o_edata), 64'h000052);
    chk("t2_oprand", 64'(o_oprand), 64'b000011);
    run_to_due("t2_due");
    chk("t2_tmr", 64'(o_tmr), 64'd20);
    pop();

    // Measure, all-qubit gate with opc2 priority, Z gate; ntp pushes in the same cycle
    instr(4'b1010, 4'b0000, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd30);
    instr(4'b0000, 4'b0100, 4'd1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 8'd31);
    chk("t3_ntp_push", 64'(o_level), 64'd1);
    instr(4'b0001, 4'b1111, 4'd4, 4'd6, 1'b0, 1'b1, 1'b0, 1'b1, 8'd32);
    flush();
    chk("t3_level", 64'(o_level), 64'd3);
    chk("t3_m_not_due", 64'(o_valid), 64'd0);
    chk("t3_m_edata", 64'(o_edata), 64'hA00000);
    chk("t3_m_oprand", 64'(o_oprand), 64'b100000);
    run_to_due("t3_m_due");
    chk("t3_m_tmr", 64'(o_tmr), 64'd30);
    pop();
    chk("t3_g1_not_due", 64'(o_valid), 64'd0);
    chk("t3_g1_edata", 64'(o_edata), 64'h001911);
    chk("t3_g1_oprand", 64'(o_oprand), 64'b001111);
    chk("t3_g1_tdata", 64'(o_tdata), 64'd31);
    run_to_due("t3_g1_due");
    pop();
    chk("t3_g2_edata", 64'(o_edata), 64'h060004);
    chk("t3_g2_oprand", 64'(o_oprand), 64'b010001);
    chk("t3_g2_tdata", 64'(o_tdata), 64'd32);
    run_to_due("t3_g2_due");
    pop();
    chk("t3_level_end", 64'(o_level), 64'd0);

    // Full FIFO backpressure; a pop frees exactly one accept
    for (int i = 0; i < 5; i++) begin
      instr(4'b0001, 4'b0000, 4'(i + 1), 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(40 + i));
    end
    chk("t4_level_full", 64'(o_level), 64'd4);
    i_rs1 = 4'b0010; i_opc1 = 4'd6; i_tdata = 8'd45; i_ntp = 1'b1; i_valid = 1'b1;
    #1;
    chk("t4_ready_full", 64'(i_ready), 64'd0);
    run_to_due("t4_due");
    chk("t4_head_tdata", 64'(o_tdata), 64'd40);
    o_ready = 1'b1;
    #1;
    chk("t4_ready_pop_cycle", 64'(i_ready), 64'd0);
    tick();
    o_ready = 1'b0;
    chk("t4_level_after_pop", 64'(o_level), 64'd3);
    chk("t4_ready_after_pop", 64'(i_ready), 64'd1);
    tick();
    i_valid = 1'b0;
    chk("t4_level_refill", 64'(o_level), 64'd4);
    chk("t4_ready_refill", 64'(i_ready), 64'd0);
    i_ntp = 1'b0;

    // Reset mid-operation discards queued and open bundles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_valid", 64'(o_valid), 64'd0);
    chk("t6_level", 64'(o_level), 64'd0);
    chk("t6_tmr", 64'(o_tmr), 64'd0);
    instr(4'b0010, 4'b0000, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    flush();
    chk("t6_fresh_level", 64'(o_level), 64'd1);
    chk("t6_fresh_edata", 64'(o_edata), 64'h000050);
    chk("t6_fresh_oprand", 64'(o_oprand), 64'b000010);
    chk("t6_fresh_tdata", 64'(o_tdata), 64'd3);
    run_to_due("t6_due");
    pop();

    // Due comparison across the timer wrap
    i_tmr_en = 1'b1;
    for (int i = 0; i < 300 && o_tmr != 8'd250; i++) begin
      tick();
    end
    i_tmr_en = 1'b0;
    chk("t5_tmr_250", 64'(o_tmr), 64'd250);
    instr(4'b1000, 4'b0000, 4'hC, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
    flush();
    chk("t5_level", 64'(o_level), 64'd1);
    i_tmr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t5_wrap_not_due", 64'(o_valid), 64'd0);
      tick();
    end
    i_tmr_en = 1'b0;
    chk("t5_tmr_4", 64'(o_tmr), 64'd4);
    chk("t5_due", 64'(o_valid), 64'd1);
    chk("t5_edata", 64'(o_edata), 64'h00C000);
    pop();
    chk("t5_level_end", 64'(o_level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpu_exu_qiu_evq.md
Name: qpu_exu_qiu_evq

Overview:
Parametrised successor to the combinational QIU event formatter. Formats quantum instructions into per-qubit XY, Z and measure event slots, and merges instructions that share a time point into one event bundle held in an accumulator. It queues closed bundles in a timestamp FIFO and releases each to the timing/event controller only when the internal timer reaches the bundle's timestamp. Sits between the QIU ALU stage (which supplies the absolute timestamp) and the QPU event issue port.

Parameters:
QUBIT_NUM, 8, number of qubits = number of XY slots; also width of the measure slot
OPC_W, 8, width of each XY/Z opcode slot
TIME_W, 16, timestamp/timer width
DEPTH, 8, bundle FIFO depth (power of two, >=2)
Derived (localparam): EVENT_NUM = QUBIT_NUM+2; EDATA_W = (QUBIT_NUM+1)*OPC_W + QUBIT_NUM

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  instruction valid
i_ready  out  1  instruction ready
i_rs1  in  QUBIT_NUM  qop1 qubit mask / measure mask
i_rs2  in  QUBIT_NUM  qop2 qubit mask
i_opc1  in  OPC_W  qop1 opcode
i_opc2  in  OPC_W  qop2 opcode
i_qop1_gate  in  1  qop1 applies to all qubits
i_qop2_gate  in  1  qop2 is a Z-slot gate
i_measure  in  1  measurement instruction
i_ntp  in  1  new time point: close the current bundle
i_tdata  in  TIME_W  absolute timestamp of the instruction
i_flush  in  1  level: close the open bundle (end of program)
i_tmr_en  in  1  timer increment enable
o_valid  out  1  due bundle valid
o_ready  in  1  consumer ready
o_edata  out  EDATA_W  bundle event data
o_oprand  out  EVENT_NUM  bundle event-valid bits
o_tdata  out  TIME_W  bundle timestamp
o_level  out  clog2(DEPTH)+1  FIFO occupancy
o_tmr  out  TIME_W  current timer

Behaviour:
- Slot formatting per instruction, as in QIU:
  - XY slot k = opc1 if (rs1[k]|qop1_gate); opc2 if (rs2[k]&~qop2_gate). When both apply, opc2 wins.
  - Z slot = opc2 if qop2_gate.
  - Measure slot = rs1 if measure. XY slots are zero when measure=1.
  - oprand[k] = XY slot written; oprand[QUBIT_NUM] = qop2_gate; oprand[QUBIT_NUM+1] = measure.
- Accumulator FSM, states ACC_EMPTY and ACC_OPEN:
  - EMPTY + accept: load the formatted bundle and i_tdata; go to OPEN. i_ntp is ignored in this state.
  - OPEN + accept with ntp=0: merge. Each written slot overwrites the accumulator slot; unwritten slots are kept; oprand bits are ORed. Accumulator tdata is kept; i_tdata is ignored.
  - OPEN + accept with ntp=1: push the accumulator to the FIFO and load the new bundle in the same cycle; stay OPEN.
  - OPEN + i_flush + FIFO not full: push; go to EMPTY.
- i_ready = ~rst & ~i_flush & ~(acc_open & i_ntp & fifo_full). A full FIFO blocks a push even when a pop occurs in the same cycle.
- Timer: resets to 0, increments by 1 when i_tmr_en, wraps modulo 2^TIME_W.
- Due condition: MSB of (tmr - head_t) == 0, computed mod 2^TIME_W. Timestamps must lie within 2^(TIME_W-1) of the timer.
- Output: o_valid = fifo_nonempty & due. o_edata/o_oprand/o_tdata come from the head entry and are held stable while o_valid=1 and o_ready=0. Pop on o_valid & o_ready.
- Latency: a bundle is pushed in its closing cycle. o_valid is asserted no earlier than the next cycle.
- Reset values: accumulator EMPTY and cleared, FIFO pointers 0, tmr=0, o_valid=0, o_level=0, outputs 0. Reset mid-operation discards all queued and open bundles.

Optional Feature:
QPU_EVQ_LATE_CNT_EN:
- Defined: adds outputs o_late (1-cycle pulse) and o_late_cnt (16 bit, saturating, reset 0). Both fire on a pop where tmr != head_t.
- Undefined: the ports are absent and no logic is built.

Decomposition:
- Package qpu_evq_pkg: slot offset functions, EVENT_NUM/EDATA_W derivation, ACC_EMPTY/ACC_OPEN encoding, and the due-compare function.
- One sub-module, qpu_evq_fifo: a synchronous FIFO with full/empty/level, used as the bundle store.

Test Plan:
- QUBIT_NUM=4, OPC_W=4. Instruction rs1=0101, opc1=3, ntp=1, tdata=10, then flush, timer enabled from 0 → o_valid rises exactly when tmr=10; XY0=3, XY2=3; oprand=000101.
- Instruction A (tdata=20, ntp=1, rs1=0001, opc1=2), then B (ntp=0, rs2=0010, opc2=5, tdata=99), then flush → one bundle with t=20, XY0=2, XY1=5, oprand=000011.
- DEPTH=4, timer disabled, 5 instructions each with ntp=1 → after 4 pushes i_ready=0 and o_level=4; one pop releases exactly one further accept.
- TIME_W=8, tmr=250, bundle t=4 → not due at 250–255; issued at tmr=4 after the wrap.
- Measure: measure=1, rs1=1010 → measure slot=1010; oprand[5]=1; XY slots and oprand[3:0] are 0.
- rst asserted with 3 bundles queued and the accumulator open → next cycle o_valid=0, o_level=0, tmr=0; a following instruction starts a fresh bundle.
